fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the main decoder. Holds the program counter, issues one-outstanding-request reads to instruction memory, and registers the returned word as the decode-stage instruction. `op` (bits 31:26) feeds the decoder's `Op` input directly. Handles decode back-pressure and branch/jump redirects, including discard of in-flight fetches.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, registered decode instruction.
// Optional `FETCH_ALIGN_CHK_EN: misaligned redirect raises sticky fetchFault and parks the FSM.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRdValid,
    input  logic [31:0] imemRdData,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pcPlus4,
    output logic        instrValid,
    input  logic        decodeStall,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        fetchFault
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
    logic              valid_q, valid_d;
    logic              kill_q, kill_d;
    logic              fault_q, fault_d;
    logic              out_free;
    logic              load;
    logic              redir_bad;
    logic [XLEN-1:0]   redir_pc;

`ifdef FETCH_ALIGN_CHK_EN
    assign redir_pc  = redirectPc;
    assign redir_bad = redirectValid && (redirectPc[1:0] != 2'b00);
`else
    assign redir_pc  = redirectPc & ~XLEN'(3);
    assign redir_bad = 1'b0;
`endif

    // Next-state, fetch handshake and output-register update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        kill_d     = kill_q;
        fault_d    = fault_q;
        imemReq    = 1'b0;
        load       = 1'b0;
        out_free   = !valid_q || !decodeStall;

        case (state_q)
            S_IDLE: begin
                if (!fault_q) state_d = S_REQ;
            end
            S_REQ: begin
                imemReq = out_free;
                if (imemReq && imemReady) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imemRdValid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    load    = !kill_q && !redirectValid;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            instr_d    = imemRdData;
            pc_plus4_d = pc_q + XLEN'(4);
            pc_d       = pc_q + XLEN'(4);
            valid_d    = 1'b1;
        end else if (valid_q && !decodeStall) begin
            valid_d = 1'b0;
        end

        // Redirect overrides everything; an in-flight request must have its data dropped
        if (redirectValid) begin
            pc_d    = redir_pc;
            valid_d = 1'b0;
            if ((state_q == S_WAIT) && !imemRdValid) kill_d = 1'b1;
            if ((state_q == S_REQ) && imemReq && imemReady) kill_d = 1'b1;
            if (redir_bad) begin
                fault_d = 1'b1;
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            kill_q     <= kill_d;
            fault_q    <= fault_d;
        end
    end

    assign imemAddr   = pc_q;
    assign instr      = instr_q;
    assign op         = instr_q[31:26];
    assign pcPlus4    = pc_plus4_q;
    assign instrValid = valid_q;
    assign fetchFault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-randomised memory model plus an
// in-order instruction-stream reference (expected PC advances by consume/redirect).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstN;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRdValid;
    logic [31:0] imemRdData;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pcPlus4;
    logic        instrValid;
    logic        decodeStall;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        fetchFault;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rstN          (rstN),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemReady     (imemReady),
        .imemRdValid   (imemRdValid),
        .imemRdData    (imemRdData),
        .instr         (instr),
        .op            (op),
        .pcPlus4       (pcPlus4),
        .instrValid    (instrValid),
        .decodeStall   (decodeStall),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .fetchFault    (fetchFault)
    );

    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic        stall, redir, rdy_rand, stale;
    logic [31:0] redir_pc;
    int          lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic [31:0] exp_pc;
    logic        exp_fault;
    logic        chk_redir;
    logic [31:0] redir_tgt;
    logic        saw_valid;
    logic [31:0] acc_q[$];
    logic [31:0] ppc_q[$];
    logic [31:0] ins_q[$];

    // Memory contents: injective over word addresses, op field varies with address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2] ^ 6'b100011, a[31:8] ^ 24'hA5A5A5, a[3:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check at negedge, advance models, return at posedge+1
    task automatic step();
        logic        acc, cons, bad;
        logic [31:0] tgt;
        logic [31:0] w;
        imemReady     = stale ? 1'b0 : (rdy_rand ? ($urandom_range(3, 0) != 0) : 1'b1);
        imemRdValid   = mem_busy && (mem_cnt == 0);
        imemRdData    = imemRdValid ? mem_word(mem_addr) : $urandom;
        decodeStall   = stall;
        redirectValid = redir;
        redirectPc    = redir_pc;
        @(negedge clk);
        if (!rstN) begin
            exp_pc    = RESET_PC;
            exp_fault = 1'b0;
            chk_redir = 1'b0;
            check1("rst_req", imemReq, 1'b0);
            check1("rst_valid", instrValid, 1'b0);
            check("rst_instr", instr, 32'h0);
            check("rst_op", 32'(op), 32'h0);
            check("rst_pcplus4", pcPlus4, 32'h0);
            check1("rst_fault", fetchFault, 1'b0);
            check("rst_addr", imemAddr, RESET_PC);
        end else begin
            check1("fault", fetchFault, exp_fault);
            if (chk_redir) begin
                check("redir_addr", imemAddr, redir_tgt);
                check1("redir_valid", instrValid, 1'b0);
            end
            if (instrValid) begin
                w = mem_word(exp_pc);
                check("instr", instr, w);
                check("pcplus4", pcPlus4, exp_pc + 32'd4);
                check("op", 32'(op), 32'(w[31:26]));
            end
            if (instrValid && decodeStall) check1("stall_req", imemReq, 1'b0);
            if (mem_busy && !stale) check1("one_outstanding", imemReq, 1'b0);
            if (exp_fault) begin
                check1("fault_req", imemReq, 1'b0);
                check1("fault_valid", instrValid, 1'b0);
            end
        end
        acc  = rstN && imemReq && imemReady;
        cons = rstN && instrValid && !decodeStall;
        if (acc) acc_q.push_back(imemAddr);
        if (cons) begin
            ppc_q.push_back(pcPlus4);
            ins_q.push_back(instr);
        end
        if (instrValid) saw_valid = 1'b1;
        chk_redir = 1'b0;
        if (rstN) begin
            if (cons && !redir) exp_pc = exp_pc + 32'd4;
            if (redir) begin
                tgt = redir_pc & ~32'h3;
                bad = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                bad = (redir_pc[1:0] != 2'b00);
`endif
                if (bad) exp_fault = 1'b1;
                else begin
                    exp_pc    = tgt;
                    chk_redir = 1'b1;
                    redir_tgt = tgt;
                end
            end
        end
        if (imemRdValid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = imemAddr;
            mem_cnt  = ((lat == 0) ? int'($urandom_range(3, 1)) : lat) - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete();
        ppc_q.delete();
        ins_q.delete();
        saw_valid = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redir    = 1'b1;
        redir_pc = pc;
        step();
        redir    = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        n_vec = 0; n_err = 0;
        stall = 0; redir = 0; redir_pc = 0; rdy_rand = 0; stale = 0; lat = 1;
        mem_busy = 0; mem_cnt = 0; mem_addr = 0;
        exp_pc = RESET_PC; exp_fault = 0; chk_redir = 0; redir_tgt = 0; saw_valid = 0;
        rstN = 1'b0;
        imemReady = 0; imemRdValid = 0; imemRdData = 0;
        decodeStall = 0; redirectValid = 0; redirectPc = 0;

        // Reset, then straight-line fetch with k=1
        @(posedge clk); #1;
        step();
        step();
        rstN = 1'b1;
        clear_q();
        repeat (14) step();
        check1("seq_acc_cnt", acc_q.size() >= 3, 1'b1);
        check1("seq_ppc_cnt", ppc_q.size() >= 3, 1'b1);
        if (acc_q.size() >= 3) begin
            check("seq_addr0", acc_q[0], 32'h0);
            check("seq_addr1", acc_q[1], 32'h4);
            check("seq_addr2", acc_q[2], 32'h8);
        end
        if (ppc_q.size() >= 3) begin
            check("seq_ppc0", ppc_q[0], 32'h4);
            check("seq_ppc1", ppc_q[1], 32'h8);
            check("seq_ppc2", ppc_q[2], 32'hC);
            w = ins_q[0];
            check("seq_op0", 32'(w[31:26]), 32'h23);
        end

        // Decode back-pressure for 5 cycles
        stall = 1'b1;
        for (int i = 0; i < 40 && !instrValid; i++) step();
        check1("stall_seen", instrValid, 1'b1);
        repeat (5) begin
            step();
            check("stall_hold", instr, mem_word(exp_pc));
            check1("stall_valid", instrValid, 1'b1);
        end
        stall = 1'b0;
        repeat (10) step();

        // Redirect while a fetch is outstanding
        lat = 3;
        for (int i = 0; i < 30 && !(mem_busy && mem_cnt > 0); i++) step();
        do_redirect(32'h40);
        clear_q();
        for (int i = 0; i < 30 && acc_q.size() == 0; i++) step();
        check1("wait_acc_cnt", acc_q.size() != 0, 1'b1);
        if (acc_q.size() != 0) check("wait_redir_addr", acc_q[0], 32'h40);
        check1("wait_dropped", saw_valid, 1'b0);
        repeat (8) step();

        // Redirect coinciding with returning data
        lat = 1;
        for (int i = 0; i < 30 && !(mem_busy && mem_cnt == 0); i++) step();
        do_redirect(32'h80);
        clear_q();
        for (int i = 0; i < 30 && acc_q.size() == 0; i++) step();
        check1("same_acc_cnt", acc_q.size() != 0, 1'b1);
        if (acc_q.size() != 0) check("same_redir_addr", acc_q[0], 32'h80);
        check1("same_dropped", saw_valid, 1'b0);
        repeat (6) step();

        // PC wrap at the top of the address space
        do_redirect(32'hFFFF_FFFC);
        clear_q();
        for (int i = 0; i < 40 && (acc_q.size() < 2 || ppc_q.size() < 1); i++) step();
        check1("wrap_cnt", (acc_q.size() >= 2) && (ppc_q.size() >= 1), 1'b1);
        if (acc_q.size() >= 2 && ppc_q.size() >= 1) begin
            check("wrap_addr0", acc_q[0], 32'hFFFF_FFFC);
            check("wrap_addr1", acc_q[1], 32'h0);
            check("wrap_ppc", ppc_q[0], 32'h0);
        end
        repeat (4) step();

        // Misaligned redirect
        do_redirect(32'h42);
        clear_q();
`ifdef FETCH_ALIGN_CHK_EN
        repeat (6) step();
        check1("align_fault", fetchFault, 1'b1);
        check1("align_no_acc", acc_q.size() == 0, 1'b1);
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        repeat (4) step();
`else
        for (int i = 0; i < 30 && acc_q.size() == 0; i++) step();
        check1("align_acc_cnt", acc_q.size() != 0, 1'b1);
        if (acc_q.size() != 0) check("align_addr", acc_q[0], 32'h40);
        check1("align_fault", fetchFault, 1'b0);
        repeat (4) step();
`endif

        // Reset during an outstanding fetch; the stale return must be ignored
        lat = 3;
        for (int i = 0; i < 30 && !(mem_busy && mem_cnt > 0); i++) step();
        rstN = 1'b0;
        step();
        rstN  = 1'b1;
        stale = 1'b1;
        repeat (5) begin
            step();
            check1("stale_valid", instrValid, 1'b0);
        end
        stale = 1'b0;
        clear_q();
        for (int i = 0; i < 30 && acc_q.size() == 0; i++) step();
        check1("rst_acc_cnt", acc_q.size() != 0, 1'b1);
        if (acc_q.size() != 0) check("rst_addr_after", acc_q[0], RESET_PC);

        // Randomised traffic against the stream model
        rdy_rand = 1'b1;
        lat      = 0;
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(9, 0) < 3);
            redir    = ($urandom_range(19, 0) == 0);
            redir_pc = $urandom;
            redir_pc[1:0] = 2'b00;
            if ($urandom_range(7, 0) == 0) redir_pc[31:8] = 24'hFF_FFFF;
            step();
        end
        redir = 1'b0;
        stall = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
